mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset (one clock; synchronous reset, active-high).
REQ-002 SHALL have: ex_valid  input  1  EX/MEM instruction present; ex_ctrl  input  rv32i_control_word  decoded control; ex_funct3  input  3  load/store width code; ex_alu_out  input  32  ALU result / effective address; ex_rs2  input  32  store source data.
REQ-003 SHALL have: mem_stall  output  1  freeze upstream; upstream holds all ex_* stable while high.
REQ-004 SHALL have: d_addr  output  32  word-aligned address; d_read  output  1; d_write  output  1; d_wmask  output  4  byte enables; d_wdata  output  32; d_resp  input  1  access complete; d_rdata  input  32  read word.
REQ-005 SHALL have: wb_valid  output  1; wb_ctrl  output  rv32i_control_word; wb_alu_out  output  32; wb_mem_data  output  32  aligned/extended load result; wb_misalign  output  1.

Function
REQ-006 SHALL implement FSM states IDLE and ACCESS.
REQ-007 Accept = ex_valid && !mem_stall at a rising edge.
REQ-008 Accepted instruction with neither ex_ctrl.d_read nor ex_ctrl.d_write SHALL appear on wb_* with wb_valid=1 the next cycle (latency 1); state stays IDLE.
REQ-009 Accepted load/store SHALL be latched and move to ACCESS; d_read or d_write SHALL assert from the next cycle and hold, with d_addr/d_wmask/d_wdata stable, until d_resp is sampled high.
REQ-010 mem_stall SHALL equal (state==ACCESS) && !d_resp.
REQ-011 On the d_resp cycle: d_rdata SHALL be captured; the next cycle SHALL present wb_valid=1 with the result; the FSM SHALL leave ACCESS; a new instruction SHALL be acceptable in that same cycle (back-to-back, zero bubble).
REQ-012 wb_valid SHALL be high exactly one cycle per retired instruction; low when nothing retires.
REQ-013 d_resp while IDLE SHALL be ignored.
REQ-014 d_addr SHALL be {ex_alu_out[31:2],2'b00}; byte offset off = ex_alu_out[1:0].
REQ-015 Store: sb -> d_wmask=4'b0001<<off, d_wdata=ex_rs2<<(8*off); sh -> d_wmask=4'b0011<<(2*off[1]), d_wdata=ex_rs2<<(16*off[1]); sw -> d_wmask=4'b1111, d_wdata=ex_rs2.
REQ-016 d_wmask SHALL be 4'b0000 whenever d_write is low.
REQ-017 Load: lb/lbu select byte off, sign-/zero-extend; lh/lhu select halfword off[1], sign-/zero-extend; lw passes d_rdata.
REQ-018 Loads with ex_ctrl.rd==0 SHALL still access memory but SHALL present wb_ctrl.load_regfile=0.
REQ-019 Undefined funct3 values SHALL behave as lw/sw.

Reset
REQ-020 With rst high at an edge: state=IDLE; d_read, d_write, wb_valid, wb_misalign, mem_stall SHALL be 0; d_wmask=0; d_addr, d_wdata, wb_alu_out, wb_mem_data=0; wb_ctrl all-zero.
REQ-021 Reset during ACCESS SHALL abandon the access; a later d_resp SHALL be ignored; no wb_valid for the abandoned instruction.

Configuration
REQ-022 Macro MEM_STAGE_MISALIGN_CHK_EN defined: lh/lhu/sh with off[0]=1, or lw/sw with off!=0, SHALL issue no memory request, SHALL retire next cycle with wb_misalign=1, wb_ctrl.load_regfile=0, wb_mem_data=0.
REQ-023 Macro undefined: no check; low address bits ignored per REQ-015/017; wb_misalign tied 0.

Structure
REQ-024 rv32i_control_word, load_funct3_t, store_funct3_t, rv32i_word and rv32i_mem_wmask SHALL come from package rv32i_types; FSM state enum stays local.
REQ-025 Byte-lane logic (REQ-015, REQ-017) SHALL be combinational sub-module mem_align.

Verification
REQ-026 Non-memory op, ex_alu_out=0x1234 -> wb_valid next cycle, wb_alu_out=0x1234, no d_read/d_write.
REQ-027 lb at 0x1003, d_resp after 3 wait cycles with d_rdata=0x80FF_FF00 -> mem_stall high 3 cycles, wb_mem_data=0xFFFF_FF80.
REQ-028 sb at 0x2002, ex_rs2=0x0000_00AB -> d_write, d_addr=0x2000, d_wmask=0100, d_wdata=0x00AB_0000; sh at 0x2002, ex_rs2=0xBEEF -> d_wmask=1100, d_wdata=0xBEEF_0000.
REQ-029 lhu at 0x3002 then lw at 0x3004 back-to-back, each d_resp in first cycle -> wb_valid on two consecutive-request boundaries; lhu with d_rdata=0xCAFE_1234 gives 0x0000_CAFE.
REQ-030 rst asserted mid-ACCESS, d_resp one cycle later -> d_read low after the reset edge, no wb_valid.
REQ-031 With MEM_STAGE_MISALIGN_CHK_EN, lw at 0x4001 -> no d_read, wb_misalign=1 next cycle; without, d_read with d_addr=0x4000.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: word and byte-enable aliases, the load/store
// funct3 encodings and the decoded control word carried down the pipeline.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       d_read;
    logic       d_write;
    logic       load_regfile;
    logic [4:0] rd;
  } rv32i_control_word;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data port: store data/byte-enable placement and
// load-result selection with sign or zero extension. Purely combinational.
// Encodings outside the defined funct3 set fall back to full-word access.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]     funct3,
  input  logic [1:0]     off,
  input  rv32i_word      st_data,
  input  rv32i_word      ld_word,
  output rv32i_mem_wmask wmask,
  output rv32i_word      wdata,
  output rv32i_word      ld_data
);

  function automatic rv32i_word sext8(input logic signed [7:0] v);
    return 32'(v);
  endfunction

  function automatic rv32i_word sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_sh  = {off, 3'b000};
  assign half_sh  = {off[1], 4'b0000};
  assign sel_byte = ld_word[byte_sh +: 8];
  assign sel_half = ld_word[half_sh +: 16];

  // Store side: move the source data up to the addressed lanes.
  always_comb begin
    wmask = 4'b1111;
    wdata = st_data;
    case (store_funct3_t'(funct3))
      sb: begin
        wmask = 4'b0001 << off;
        wdata = st_data << byte_sh;
      end
      sh: begin
        wmask = 4'b0011 << {off[1], 1'b0};
        wdata = st_data << half_sh;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed byte/halfword and extend to a full word.
  always_comb begin
    ld_data = ld_word;
    case (load_funct3_t'(funct3))
      lb:      ld_data = sext8(sel_byte);
      lbu:     ld_data = {24'b0, sel_byte};
      lh:      ld_data = sext16(sel_half);
      lhu:     ld_data = {16'b0, sel_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage. Non-memory ops retire one cycle after acceptance; loads
// and stores hold a request on the data port until d_resp, then retire the
// following cycle while a new instruction may be accepted in the same cycle.
// A one-entry hold slot absorbs the case where a direct retirement lands on
// the same edge as a memory response, so wb_valid never fires twice at once.
// Optional: define MEM_STAGE_MISALIGN_CHK_EN to retire misaligned half/word
// accesses immediately with wb_misalign set and no memory request.
module mem_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  rv32i_control_word ex_ctrl,
  input  logic [2:0]        ex_funct3,
  input  rv32i_word         ex_alu_out,
  input  rv32i_word         ex_rs2,
  output logic              mem_stall,
  output rv32i_word         d_addr,
  output logic              d_read,
  output logic              d_write,
  output rv32i_mem_wmask    d_wmask,
  output rv32i_word         d_wdata,
  input  logic              d_resp,
  input  rv32i_word         d_rdata,
  output logic              wb_valid,
  output rv32i_control_word wb_ctrl,
  output rv32i_word         wb_alu_out,
  output rv32i_word         wb_mem_data,
  output logic              wb_misalign
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    rv32i_control_word ctrl;
    rv32i_word         alu_out;
    rv32i_word         mem_data;
    logic              misalign;
  } retire_t;

  state_t            state, next_state;
  rv32i_control_word ctrl_p1;
  logic [2:0]        funct3_p1;
  rv32i_word         alu_p1, rs2_p1;
  retire_t           hold_p1, wb_p2, direct_rec, resp_rec;
  logic              hold_vld_p1, vld_p2;
  rv32i_mem_wmask    lane_wmask;
  rv32i_word         lane_wdata, lane_ld;
  logic              is_mem, misalign_ex, accept, start_access;
  logic              direct_ret, resp_ret;

`ifdef MEM_STAGE_MISALIGN_CHK_EN
  function automatic logic misaligned(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic bad;
    if (is_store) begin
      case (store_funct3_t'(funct3))
        sb:      bad = 1'b0;
        sh:      bad = off[0];
        default: bad = (off != 2'b00);
      endcase
    end else begin
      case (load_funct3_t'(funct3))
        lb, lbu: bad = 1'b0;
        lh, lhu: bad = off[0];
        default: bad = (off != 2'b00);
      endcase
    end
    return bad;
  endfunction

  assign misalign_ex = is_mem && misaligned(ex_ctrl.d_write, ex_funct3, ex_alu_out[1:0]);
`else
  assign misalign_ex = 1'b0;
`endif

  assign is_mem       = ex_ctrl.d_read || ex_ctrl.d_write;
  assign mem_stall    = (state == ACCESS) && !d_resp;
  assign accept       = ex_valid && !mem_stall;
  assign start_access = accept && is_mem && !misalign_ex;
  assign direct_ret   = accept && !start_access;
  assign resp_ret     = (state == ACCESS) && d_resp;

  mem_align u_align (
    .funct3  (funct3_p1),
    .off     (alu_p1[1:0]),
    .st_data (rs2_p1),
    .ld_word (d_rdata),
    .wmask   (lane_wmask),
    .wdata   (lane_wdata),
    .ld_data (lane_ld)
  );

  assign d_read  = (state == ACCESS) && ctrl_p1.d_read;
  assign d_write = (state == ACCESS) && ctrl_p1.d_write;
  assign d_addr  = {alu_p1[31:2], 2'b00};
  assign d_wmask = d_write ? lane_wmask : 4'b0000;
  assign d_wdata = lane_wdata;

  assign wb_valid    = vld_p2;
  assign wb_ctrl     = wb_p2.ctrl;
  assign wb_alu_out  = wb_p2.alu_out;
  assign wb_mem_data = wb_p2.mem_data;
  assign wb_misalign = wb_p2.misalign;

  // Retirement records for the direct path and for a completing access.
  always_comb begin
    direct_rec          = '0;
    direct_rec.ctrl     = ex_ctrl;
    direct_rec.alu_out  = ex_alu_out;
    direct_rec.misalign = misalign_ex;
    if (misalign_ex) direct_rec.ctrl.load_regfile = 1'b0;

    resp_rec          = '0;
    resp_rec.ctrl     = ctrl_p1;
    resp_rec.alu_out  = alu_p1;
    resp_rec.mem_data = ctrl_p1.d_read ? lane_ld : 32'b0;
    if (ctrl_p1.d_read && (ctrl_p1.rd == 5'd0)) resp_rec.ctrl.load_regfile = 1'b0;
  end

  // FSM next state: enter ACCESS on a real request, leave on d_resp unless chained.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_access) next_state = ACCESS;
      ACCESS:  if (d_resp) next_state = start_access ? ACCESS : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // EX -> access stage: latch the request fields for the duration of ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p1   <= '0;
      funct3_p1 <= '0;
      alu_p1    <= '0;
      rs2_p1    <= '0;
    end else if (start_access) begin
      ctrl_p1   <= ex_ctrl;
      funct3_p1 <= ex_funct3;
      alu_p1    <= ex_alu_out;
      rs2_p1    <= ex_rs2;
    end
  end

  // Access -> writeback stage: one retirement per cycle, response first.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2      <= 1'b0;
      wb_p2       <= '0;
      hold_vld_p1 <= 1'b0;
    end else begin
      vld_p2 <= resp_ret || hold_vld_p1 || direct_ret;
      if (resp_ret)         wb_p2 <= resp_rec;
      else if (hold_vld_p1) wb_p2 <= hold_p1;
      else if (direct_ret)  wb_p2 <= direct_rec;
      if (resp_ret || hold_vld_p1) begin
        hold_vld_p1 <= direct_ret;
        hold_p1     <= direct_rec;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a queue-based model of retirements (in order,
// at most one per cycle) checked every cycle, plus literal expectations.
module tb_mem_stage;
  import rv32i_types::*;

`ifdef MEM_STAGE_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk, rst, ex_valid, d_resp;
  rv32i_control_word ex_ctrl, wb_ctrl;
  logic [2:0]        ex_funct3;
  logic [31:0]       ex_alu_out, ex_rs2, d_addr, d_wdata, d_rdata, wb_alu_out, wb_mem_data;
  logic              mem_stall, d_read, d_write, wb_valid, wb_misalign;
  logic [3:0]        d_wmask;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_funct3(ex_funct3),
    .ex_alu_out(ex_alu_out), .ex_rs2(ex_rs2), .mem_stall(mem_stall), .d_addr(d_addr),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
    .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_misalign(wb_misalign)
  );

  typedef struct {
    rv32i_control_word ctrl;
    logic [31:0]       alu;
    logic [31:0]       mem;
    logic              chk_mem;
    logic              mis;
    int                due;
  } exp_t;

  exp_t        q[$];
  exp_t        cmp_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  bit          started = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wmask;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic rv32i_control_word mk(input logic rdm, input logic wrm,
                                           input logic [4:0] rd, input logic lr);
    rv32i_control_word c;
    c = '0;
    c.alu_op = 4'hA;
    c.d_read = rdm;
    c.d_write = wrm;
    c.rd = rd;
    c.load_regfile = lr;
    return c;
  endfunction

  function automatic bit model_misal(input bit st, input logic [2:0] f3, input logic [1:0] off);
    bit bad;
    if (st) bad = (f3 == 3'd0) ? 1'b0 : (f3 == 3'd1) ? off[0] : (off != 0);
    else    bad = (f3 == 3'd0 || f3 == 3'd4) ? 1'b0 :
                  (f3 == 3'd1 || f3 == 3'd5) ? off[0] : (off != 0);
    return CHK_EN && bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
    int b, h;
    b = int'((rd >> (8 * off)) & 32'hFF);
    h = int'((rd >> (16 * off[1])) & 32'hFFFF);
    case (f3)
      3'd0:    return 32'((b >= 128) ? b - 256 : b);
      3'd4:    return 32'(b);
      3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
      3'd5:    return 32'(h);
      default: return rd;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rs2,
                             output logic [3:0] m, output logic [31:0] d);
    case (f3)
      3'd0:    begin m = 4'(1 << off);        d = rs2 << (8 * off); end
      3'd1:    begin m = 4'(3 << (2 * off[1])); d = rs2 << (16 * off[1]); end
      default: begin m = 4'hF;                d = rs2; end
    endcase
  endtask

  function automatic exp_t model(input rv32i_control_word c, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rdata);
    exp_t e;
    e.ctrl = c; e.alu = addr; e.mem = 0; e.chk_mem = 0; e.due = 0;
    e.mis = (c.d_read || c.d_write) && model_misal(c.d_write, f3, addr[1:0]);
    if (e.mis) begin
      e.ctrl.load_regfile = 1'b0;
      e.chk_mem = 1'b1;
    end else if (c.d_read) begin
      e.chk_mem = 1'b1;
      e.mem = model_load(f3, addr[1:0], rdata);
      if (c.rd == 5'd0) e.ctrl.load_regfile = 1'b0;
    end
    return e;
  endfunction

  // Retirements leave in order, at most one per cycle.
  task automatic push(input exp_t e, input int nat);
    e.due = (nat > last_due) ? nat : last_due + 1;
    last_due = e.due;
    q.push_back(e);
  endtask

  // Issue one instruction at a negedge; returns at the negedge where it retires.
  task automatic mem_op(input rv32i_control_word c, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int waits);
    exp_t        e;
    bit          acc;
    logic [3:0]  m;
    logic [31:0] wd;
    e = model(c, f3, addr, rdata);
    acc = (c.d_read || c.d_write) && !e.mis;
    ex_ctrl = c; ex_funct3 = f3; ex_alu_out = addr; ex_rs2 = rs2; ex_valid = 1'b1;
    push(e, acc ? cyc + 2 + waits : cyc + 1);
    @(negedge clk);
    ex_valid = 1'b0;
    if (!acc) begin
      chk("no_read", d_read, 1'b0);
      chk("no_write", d_write, 1'b0);
      return;
    end
    model_store(f3, addr[1:0], rs2, m, wd);
    for (int i = 0; i <= waits; i++) begin
      chk("d_read", d_read, c.d_read);
      chk("d_write", d_write, c.d_write);
      chk("d_addr", d_addr, {addr[31:2], 2'b00});
      chk("d_wmask", d_wmask, c.d_write ? m : 4'b0000);
      if (c.d_write) chk("d_wdata", d_wdata, wd);
      if (i < waits) begin
        chk("stall_wait", mem_stall, 1'b1);
        @(negedge clk);
      end
    end
    seen_addr = d_addr; seen_wmask = d_wmask; seen_wdata = d_wdata;
    d_resp = 1'b1; d_rdata = rdata;
    #1 chk("stall_resp", mem_stall, 1'b0);
    @(negedge clk);
    d_resp = 1'b0; d_rdata = 32'h0;
  endtask

  // Every cycle: wb_valid exactly when the model has a retirement due, with its fields.
  always @(negedge clk) begin
    if (started) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        cmp_e = q.pop_front();
        chk("wb_valid", wb_valid, 1'b1);
        if (wb_valid) begin
          chk("wb_alu_out", wb_alu_out, cmp_e.alu);
          chk("wb_ctrl", 32'(wb_ctrl), 32'(cmp_e.ctrl));
          chk("wb_misalign", wb_misalign, cmp_e.mis);
          if (cmp_e.chk_mem) chk("wb_mem_data", wb_mem_data, cmp_e.mem);
        end
      end else begin
        chk("wb_idle", wb_valid, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rdm, wrm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          waits;
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[9];
  rv32i_control_word c;

  initial begin
    vecs[0] = '{1, 0, 5'd1, 3'd4, 32'h7001, 32'h0,        32'h1234_80FF, 1, 32'h0000_0080};
    vecs[1] = '{1, 0, 5'd2, 3'd1, 32'h7002, 32'h0,        32'h8001_0000, 0, 32'hFFFF_8001};
    vecs[2] = '{1, 0, 5'd3, 3'd1, 32'h7000, 32'h0,        32'h8001_7FFE, 2, 32'h0000_7FFE};
    vecs[3] = '{1, 0, 5'd4, 3'd0, 32'h7000, 32'h0,        32'hFFFF_FF7F, 0, 32'h0000_007F};
    vecs[4] = '{1, 0, 5'd0, 3'd2, 32'h7008, 32'h0,        32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[5] = '{1, 0, 5'd5, 3'd3, 32'h700C, 32'h0,        32'h0102_0304, 0, 32'h0102_0304};
    vecs[6] = '{0, 1, 5'd0, 3'd2, 32'h7010, 32'hDEAD_BEEF, 32'h0,        1, 32'hDEAD_BEEF};
    vecs[7] = '{0, 1, 5'd0, 3'd7, 32'h7014, 32'h5566_7788, 32'h0,        0, 32'h5566_7788};
    vecs[8] = '{0, 1, 5'd0, 3'd0, 32'h7013, 32'h0000_00C3, 32'h0,        2, 32'hC300_0000};

    rst = 1'b1; ex_valid = 1'b0; ex_ctrl = '0; ex_funct3 = 3'd0; ex_alu_out = 32'h0;
    ex_rs2 = 32'h0; d_resp = 1'b0; d_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_d_read", d_read, 1'b0);
    chk("rst_d_write", d_write, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_misalign", wb_misalign, 1'b0);
    chk("rst_mem_stall", mem_stall, 1'b0);
    chk("rst_d_wmask", d_wmask, 4'b0000);
    chk("rst_d_addr", d_addr, 32'h0);
    chk("rst_d_wdata", d_wdata, 32'h0);
    chk("rst_wb_alu_out", wb_alu_out, 32'h0);
    chk("rst_wb_mem_data", wb_mem_data, 32'h0);
    chk("rst_wb_ctrl", 32'(wb_ctrl), 32'h0);
    rst = 1'b0;
    started = 1;
    @(negedge clk);

    // Non-memory op retires the next cycle.
    mem_op(mk(0, 0, 5'd3, 1), 3'd0, 32'h1234, 32'h0, 32'h0, 0);
    chk("alu_lit_valid", wb_valid, 1'b1);
    chk("alu_lit", wb_alu_out, 32'h0000_1234);

    // lb at 0x1003 with three wait cycles.
    mem_op(mk(1, 0, 5'd6, 1), 3'd0, 32'h1003, 32'h0, 32'h80FF_FF00, 3);
    chk("lb_lit", wb_mem_data, 32'hFFFF_FF80);

    // sb / sh at 0x2002.
    mem_op(mk(0, 1, 5'd0, 0), 3'd0, 32'h2002, 32'h0000_00AB, 32'h0, 0);
    chk("sb_addr_lit", seen_addr, 32'h2000);
    chk("sb_mask_lit", seen_wmask, 4'b0100);
    chk("sb_data_lit", seen_wdata, 32'h00AB_0000);
    mem_op(mk(0, 1, 5'd0, 0), 3'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 1);
    chk("sh_mask_lit", seen_wmask, 4'b1100);
    chk("sh_data_lit", seen_wdata, 32'hBEEF_0000);

    // lhu 0x3002 then lw 0x3004 back to back, each answered at once.
    c = mk(1, 0, 5'd7, 1);
    ex_ctrl = c; ex_funct3 = 3'd5; ex_alu_out = 32'h3002; ex_rs2 = 32'h0; ex_valid = 1'b1;
    push(model(c, 3'd5, 32'h3002, 32'hCAFE_1234), cyc + 2);
    @(negedge clk);
    chk("b2b_read0", d_read, 1'b1);
    chk("b2b_addr0", d_addr, 32'h3000);
    d_resp = 1'b1; d_rdata = 32'hCAFE_1234;
    ex_funct3 = 3'd2; ex_alu_out = 32'h3004;
    push(model(c, 3'd2, 32'h3004, 32'h1122_3344), cyc + 2);
    #1 chk("b2b_stall", mem_stall, 1'b0);
    @(negedge clk);
    chk("b2b_wb0", wb_valid, 1'b1);
    chk("lhu_lit", wb_mem_data, 32'h0000_CAFE);
    chk("b2b_read1", d_read, 1'b1);
    chk("b2b_addr1", d_addr, 32'h3004);
    d_rdata = 32'h1122_3344; ex_valid = 1'b0;
    @(negedge clk);
    d_resp = 1'b0;
    chk("b2b_wb1", wb_valid, 1'b1);
    chk("lw_lit", wb_mem_data, 32'h1122_3344);
    chk("b2b_idle", d_read, 1'b0);

    // Directed load/store vectors, including rd=0 and undefined funct3.
    foreach (vecs[i]) begin
      mem_op(mk(vecs[i].rdm, vecs[i].wrm, vecs[i].rd, 1), vecs[i].f3, vecs[i].addr,
             vecs[i].rs2, vecs[i].rdata, vecs[i].waits);
      if (vecs[i].rdm) chk("vec_load_lit", wb_mem_data, vecs[i].lit);
      else             chk("vec_store_lit", seen_wdata, vecs[i].lit);
      if (vecs[i].rdm && vecs[i].rd == 5'd0) chk("rd0_no_load", wb_ctrl.load_regfile, 1'b0);
    end

    // Misaligned word load at 0x4001.
    mem_op(mk(1, 0, 5'd8, 1), 3'd2, 32'h4001, 32'h0, 32'h5A5A_5A5A, 0);
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    chk("mis_lit", wb_misalign, 1'b1);
    chk("mis_lr_lit", wb_ctrl.load_regfile, 1'b0);
    chk("mis_data_lit", wb_mem_data, 32'h0);
    mem_op(mk(0, 1, 5'd0, 0), 3'd1, 32'h4003, 32'h1234, 32'h0, 0);
    chk("mis_sh_lit", wb_misalign, 1'b1);
`else
    chk("nomis_addr_lit", seen_addr, 32'h4000);
    chk("nomis_flag_lit", wb_misalign, 1'b0);
`endif

    // Non-memory ops arriving on and after a response cycle queue up behind it.
    c = mk(1, 0, 5'd4, 1);
    ex_ctrl = c; ex_funct3 = 3'd2; ex_alu_out = 32'h6000; ex_valid = 1'b1;
    push(model(c, 3'd2, 32'h6000, 32'h0BAD_F00D), cyc + 2);
    @(negedge clk);
    chk("skid_read", d_read, 1'b1);
    d_resp = 1'b1; d_rdata = 32'h0BAD_F00D;
    c = mk(0, 0, 5'd9, 1);
    ex_ctrl = c; ex_alu_out = 32'hA0;
    push(model(c, 3'd2, 32'hA0, 32'h0), cyc + 1);
    @(negedge clk);
    d_resp = 1'b0; d_rdata = 32'h0;
    chk("skid_lw_data", wb_mem_data, 32'h0BAD_F00D);
    ex_alu_out = 32'hB0;
    push(model(c, 3'd2, 32'hB0, 32'h0), cyc + 1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("skid_a_lit", wb_alu_out, 32'hA0);
    @(negedge clk);
    chk("skid_b_lit", wb_alu_out, 32'hB0);
    @(negedge clk);

    // Reset in the middle of an access; the late response must be ignored.
    c = mk(1, 0, 5'd2, 1);
    ex_ctrl = c; ex_funct3 = 3'd2; ex_alu_out = 32'h5000; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("abort_read", d_read, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_read_low", d_read, 1'b0);
    chk("abort_stall_low", mem_stall, 1'b0);
    rst = 1'b0; d_resp = 1'b1; d_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    d_resp = 1'b0;
    chk("late_resp_read", d_read, 1'b0);
    chk("late_resp_wb", wb_valid, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
